tt09_counter_seq_checker: RTL
=============================

// Module: tt09_counter_seq_checker
// PURPOSE
//  Receive-side checker for the free-running incrementing counter pattern our TT designs drive on a bus.
//  Samples the incoming counter bus, locks onto the sequence and flags every sample that breaks it.
//  Counts errors and reports lock state, so a second tile or the FPGA harness can verify a counter source.
//  Sits behind ui_in in the top wrapper. Outputs go to uo_out/uio_out for bring-up.
// PARAMETERS
//  WIDTH          8   data bus width; sequence arithmetic is modulo 2^WIDTH
//  ERR_CNT_W      8   width of the saturating error counter
//  LOCK_THRESH    4   consecutive correct predictions required to enter LOCKED (>=1)
//  UNLOCK_THRESH  3   consecutive mismatches in LOCKED that drop back to HUNT (>=1)
// PORTS
//  clk        in   1          clock
//  rst_n      in   1          synchronous reset, active-low
//  en         in   1          sample strobe; data_in is only evaluated when en=1
//  data_in    in   WIDTH      counter value under test
//  clear      in   1          synchronous clear of err_count
//  locked     out  1          1 while FSM is in LOCKED
//  err_pulse  out  1          1-cycle pulse per counted mismatch
//  err_count  out  ERR_CNT_W  saturating count of mismatches seen while LOCKED
//  state_o    out  2          current FSM state (debug)
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=HUNT, expected=0, good_cnt=0, bad_cnt=0.
//    locked=0, err_pulse=0, err_count=0. Reset mid-operation discards all history. No partial lock survives.
//  - All outputs are registered. The response to a sample at edge N is visible after edge N.
//  - en=0: FSM, expected, good_cnt, bad_cnt and err_count hold. err_pulse=0. clear still acts.
//  - "match" means data_in == expected. expected wraps: 2^WIDTH-1 -> 0 is a match, never an error.
//  - HUNT: on en, expected<=data_in+1, good_cnt<=0, go ACQUIRE. No error is ever counted.
//  - ACQUIRE, on en:
//    - match: expected<=expected+1, good_cnt++.
//      When good_cnt reaches LOCK_THRESH: go LOCKED, bad_cnt<=0.
//    - mismatch: reseed expected<=data_in+1, good_cnt<=0, stay in ACQUIRE. No error is counted.
//  - LOCKED, on en (flywheel: expected<=expected+1 always, so one glitch costs exactly one error):
//    - match: bad_cnt<=0.
//    - mismatch: err_pulse<=1, err_count saturating +1, bad_cnt++.
//      When bad_cnt reaches UNLOCK_THRESH: go HUNT, and locked falls on the same edge.
//  - err_count saturates at 2^ERR_CNT_W-1 and does not wrap.
//  - clear=1 forces err_count<=0 and has priority over a simultaneous increment.
//    err_pulse still fires for that sample.
//  - Lock timing: with continuous en, lock takes 1 seed sample + LOCK_THRESH matches.
//    locked rises after the edge of sample LOCK_THRESH+1.
//  - good_cnt and bad_cnt are sized $clog2(max(THRESH)+1) and never exceed their threshold.
// STRUCTURE
//  - Shared package tt09_pkg: state encoding localparams ST_HUNT=2'd0, ST_ACQUIRE=2'd1, ST_LOCKED=2'd2.
//    Encoding 2'd3 is illegal and recovers to HUNT.
//  - One sub-module: tt09_sat_counter (WIDTH param; inc, clr with clr priority; saturating).
//    err_count uses it, and it is reusable elsewhere.
//  - Everything else (FSM, expected register, run counters) is flat in this module.
//  - Top wrapper mapping: data_in=ui_in, en=uio_in[0], clear=uio_in[1], uo_out=err_count,
//    uio_out[7:6]={err_pulse,locked}.
// TESTING
//  1. Reset, then en=1 with data 0x00,0x01,... through a wrap to 0x10.
//     -> locked=1 after the 5th sample's edge. err_count=0 across the 0xFF->0x00 wrap. err_pulse never asserts.
//  2. Locked, 0x40 replaced by 0x55 once.
//     -> err_pulse high exactly 1 cycle, err_count=1, locked stays 1. The following 0x41 matches.
//  3. Locked, three consecutive bad samples (0x00,0x00,0x00 where 0x20..0x22 expected).
//     -> err_count=3, locked=0 after the 3rd. A clean sequence re-locks after 5 samples.
//  4. en toggled 0/1 with random data_in while en=0.
//     -> no state, err_count or locked change during en=0 cycles. The sequence keeps matching.
//  5. clear asserted on the same edge as a LOCKED mismatch.
//     -> err_pulse=1, err_count=0. Then force 300 errors without clear -> err_count holds 0xFF.
//  6. rst_n=0 for one cycle while LOCKED with err_count=7.
//     -> next cycle locked=0, err_count=0, state_o=HUNT. Re-lock requires the full 5 samples.

Source files
------------

// File: rtl/tt09_pkg.sv
// Shared definitions for the tt09 counter-sequence checker family.
package tt09_pkg;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_ILLEGAL = 2'd3
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tt09_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module tt09_sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_d;

  always_comb begin
    w_count_d = r_count;
    if (clr) begin
      w_count_d = '0;
    end else if (inc && (r_count != '1)) begin
      w_count_d = r_count + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_d;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/tt09_counter_seq_checker.sv
// Locks onto an incrementing counter stream and counts samples that break it once locked.
module tt09_counter_seq_checker
  import tt09_pkg::*;
#(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned ERR_CNT_W     = 8,
  parameter int unsigned LOCK_THRESH   = 4,
  parameter int unsigned UNLOCK_THRESH = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 clear,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [1:0]           state_o
);

  localparam int unsigned CntW = $clog2(max_u(LOCK_THRESH, UNLOCK_THRESH) + 1);
  localparam logic [CntW-1:0] LockThr   = CntW'(LOCK_THRESH);
  localparam logic [CntW-1:0] UnlockThr = CntW'(UNLOCK_THRESH);

  state_e           r_state, w_state_d;
  logic [WIDTH-1:0] r_expected, w_expected_d;
  logic [CntW-1:0]  r_good_cnt, w_good_cnt_d;
  logic [CntW-1:0]  r_bad_cnt, w_bad_cnt_d;
  logic             r_locked;
  logic             r_err_pulse, w_err_pulse_d;
  logic             w_err_inc;
  logic             w_match;

  assign w_match = (data_in == r_expected);

  always_comb begin
    w_state_d     = r_state;
    w_expected_d  = r_expected;
    w_good_cnt_d  = r_good_cnt;
    w_bad_cnt_d   = r_bad_cnt;
    w_err_pulse_d = 1'b0;
    w_err_inc     = 1'b0;
    case (r_state)
      ST_HUNT: begin
        if (en) begin
          w_expected_d = data_in + WIDTH'(1);
          w_good_cnt_d = '0;
          w_state_d    = ST_ACQUIRE;
        end
      end
      ST_ACQUIRE: begin
        if (en) begin
          if (w_match) begin
            w_expected_d = r_expected + WIDTH'(1);
            if (r_good_cnt + CntW'(1) == LockThr) begin
              w_good_cnt_d = '0;
              w_bad_cnt_d  = '0;
              w_state_d    = ST_LOCKED;
            end else begin
              w_good_cnt_d = r_good_cnt + CntW'(1);
            end
          end else begin
            w_expected_d = data_in + WIDTH'(1);
            w_good_cnt_d = '0;
          end
        end
      end
      ST_LOCKED: begin
        if (en) begin
          // Flywheel: prediction advances even on a mismatch, so a glitch costs one error.
          w_expected_d = r_expected + WIDTH'(1);
          if (w_match) begin
            w_bad_cnt_d = '0;
          end else begin
            w_err_pulse_d = 1'b1;
            w_err_inc     = 1'b1;
            if (r_bad_cnt + CntW'(1) == UnlockThr) begin
              w_bad_cnt_d = '0;
              w_state_d   = ST_HUNT;
            end else begin
              w_bad_cnt_d = r_bad_cnt + CntW'(1);
            end
          end
        end
      end
      default: begin
        w_state_d = ST_HUNT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_HUNT;
      r_expected  <= '0;
      r_good_cnt  <= '0;
      r_bad_cnt   <= '0;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_expected  <= w_expected_d;
      r_good_cnt  <= w_good_cnt_d;
      r_bad_cnt   <= w_bad_cnt_d;
      r_locked    <= (w_state_d == ST_LOCKED);
      r_err_pulse <= w_err_pulse_d;
    end
  end

  tt09_sat_counter #(
    .WIDTH(ERR_CNT_W)
  ) u_err_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (w_err_inc),
    .clr  (clear),
    .count(err_count)
  );

  assign locked    = r_locked;
  assign err_pulse = r_err_pulse;
  assign state_o   = r_state;

endmodule
